// File: rtl/uart_cmd_framer_if.sv
// Byte-stream bus between a UART receiver, the command framer and the payload consumer.
interface uart_cmd_framer_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       pkt_ok;
  logic       pkt_err;
  logic       drop;
  logic       busy;

  // Environment side: feeds received bytes and consumes payload.
  modport master (
    output rx_data, rx_valid, out_ready,
    input  out_data, out_valid, out_last, pkt_ok, pkt_err, drop, busy
  );

  // Framer side.
  modport slave (
    input  rx_data, rx_valid, out_ready,
    output out_data, out_valid, out_last, pkt_ok, pkt_err, drop, busy
  );
endinterface

// File: rtl/uart_cmd_framer.sv
// Frames SYNC/LEN/payload/checksum packets from a UART byte stream, buffers the
// payload and replays it to a ready/valid consumer once the checksum passes.
module uart_cmd_framer #(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned TIMEOUT = 1024,
  parameter logic [7:0]  SYNC    = 8'hA5
) (
  input logic              clk,
  input logic              rst_n,
  uart_cmd_framer_if.slave bus
);

  localparam int unsigned IDX_W     = $clog2(MAX_LEN + 1);
  localparam int unsigned ADDR_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TMR_W     = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CSUM,
    S_DRAIN
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] len_q, len_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       acc_q, acc_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             pkt_ok_q, pkt_ok_d;
  logic             pkt_err_q, pkt_err_d;
  logic             drop_q, drop_d;
  logic             busy_q;
  logic             buf_we;

  logic [7:0]       mem [MAX_LEN];

  logic [7:0]       sum_c;
  logic [IDX_W-1:0] idx_inc_c;
  logic [IDX_W-1:0] len_last_c;
  logic             expired_c;

  assign sum_c      = acc_q + bus.rx_data;
  assign idx_inc_c  = idx_q + IDX_W'(1);
  assign len_last_c = len_q - IDX_W'(1);
  // Silence for TIMEOUT cycles; a byte in the expiry cycle takes precedence.
  assign expired_c  = !bus.rx_valid && (tmr_q == TMR_LAST);

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    tmr_d       = tmr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    pkt_ok_d    = 1'b0;
    pkt_err_d   = 1'b0;
    drop_d      = 1'b0;
    buf_we      = 1'b0;

    case (state_q)
      S_IDLE: begin
        tmr_d = '0;
        idx_d = '0;
        if (bus.rx_valid && (bus.rx_data == SYNC)) begin
          state_d = S_LEN;
        end
      end

      S_LEN: begin
        if (bus.rx_valid) begin
          tmr_d = '0;
          acc_d = bus.rx_data;
          if ((bus.rx_data == 8'h00) || (bus.rx_data > MAX_LEN_B)) begin
            pkt_err_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            len_d   = IDX_W'(bus.rx_data);
            idx_d   = '0;
            state_d = S_PAYLOAD;
          end
        end else if (expired_c) begin
          pkt_err_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      S_PAYLOAD: begin
        if (bus.rx_valid) begin
          tmr_d  = '0;
          buf_we = 1'b1;
          acc_d  = sum_c;
          idx_d  = idx_inc_c;
          if (idx_q == len_last_c) begin
            state_d = S_CSUM;
          end
        end else if (expired_c) begin
          pkt_err_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      S_CSUM: begin
        if (bus.rx_valid) begin
          tmr_d = '0;
          if (sum_c == 8'h00) begin
            pkt_ok_d    = 1'b1;
            state_d     = S_DRAIN;
            idx_d       = '0;
            out_valid_d = 1'b1;
            out_data_d  = mem[0];
            out_last_d  = (len_q == IDX_W'(1));
          end else begin
            pkt_err_d = 1'b1;
            state_d   = S_IDLE;
          end
        end else if (expired_c) begin
          pkt_err_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      S_DRAIN: begin
        drop_d = bus.rx_valid;
        if (out_valid_q && bus.out_ready) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            idx_d       = '0;
            state_d     = S_IDLE;
          end else begin
            idx_d      = idx_inc_c;
            out_data_d = mem[ADDR_W'(idx_inc_c)];
            out_last_d = (idx_inc_c == len_last_c);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      tmr_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      pkt_ok_q    <= 1'b0;
      pkt_err_q   <= 1'b0;
      drop_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      tmr_q       <= tmr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      pkt_ok_q    <= pkt_ok_d;
      pkt_err_q   <= pkt_err_d;
      drop_q      <= drop_d;
      busy_q      <= (state_d != S_IDLE);
    end
  end

  // Payload buffer; contents only matter after a full payload has been written.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      mem[ADDR_W'(idx_q)] <= bus.rx_data;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.pkt_ok    = pkt_ok_q;
  assign bus.pkt_err   = pkt_err_q;
  assign bus.drop      = drop_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Self-checking bench for uart_cmd_framer: packet-level model plus a per-cycle compare process.
module tb_uart_cmd_framer;

  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned TIMEOUT = 1024;
  localparam logic [7:0]  SYNC    = 8'hA5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  uart_cmd_framer_if bus ();

  uart_cmd_framer #(
    .MAX_LEN (MAX_LEN),
    .TIMEOUT (TIMEOUT),
    .SYNC    (SYNC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // Expected pulse edges and expected payload stream {last, data}.
  int unsigned ok_q[$];
  int unsigned err_q[$];
  int unsigned drop_q[$];
  logic [8:0]  exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
    end
  endtask

  // Per-cycle compare against the model's expectations.
  always @(negedge clk) begin
    bit e_ok, e_err, e_drop;
    if (rst_n) begin
      e_ok = (ok_q.size() > 0) && (ok_q[0] == cyc);
      if (e_ok) void'(ok_q.pop_front());
      e_err = (err_q.size() > 0) && (err_q[0] == cyc);
      if (e_err) void'(err_q.pop_front());
      e_drop = (drop_q.size() > 0) && (drop_q[0] == cyc);
      if (e_drop) void'(drop_q.pop_front());
      chk("pkt_ok", 32'(bus.pkt_ok), 32'(e_ok));
      chk("pkt_err", 32'(bus.pkt_err), 32'(e_err));
      chk("drop", 32'(bus.drop), 32'(e_drop));
      if (bus.pkt_ok) chk("valid_with_ok", 32'(bus.out_valid), 32'd1);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 32'(bus.out_valid), 32'd0);
        end else begin
          chk("out_data", 32'(bus.out_data), 32'(exp_q[0][7:0]));
          chk("out_last", 32'(bus.out_last), 32'(exp_q[0][8]));
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end else begin
        chk("last_without_valid", 32'(bus.out_last), 32'd0);
      end
    end
  end

  // Packet model: p holds the bytes after SYNC. Returns 0 incomplete, 1 ok, 2 err;
  // dec is the index of the byte that decides the outcome.
  function automatic int verdict(input logic [7:0] p[$], output int dec);
    int unsigned len;
    logic [7:0]  s;
    dec = -1;
    if (p.size() == 0) return 0;
    len = int'(p[0]);
    if (len == 0 || len > MAX_LEN) begin
      dec = 0;
      return 2;
    end
    if (p.size() < int'(len) + 2) return 0;
    s = 8'h00;
    for (int i = 0; i <= int'(len) + 1; i++) s = s + p[i];
    dec = int'(len) + 1;
    return (s == 8'h00) ? 1 : 2;
  endfunction

  function automatic logic [7:0] csum_of(input logic [7:0] body[$]);
    logic [7:0] s;
    s = 8'h00;
    foreach (body[i]) s = s + body[i];
    return 8'h00 - s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // kind: 0 none, 1 pkt_ok, 2 pkt_err, 3 drop expected after the sampling edge.
  task automatic send_byte(input logic [7:0] b, input int kind, output int unsigned edge_n);
    edge_n = cyc + 1;
    case (kind)
      1: ok_q.push_back(edge_n);
      2: err_q.push_back(edge_n);
      3: drop_q.push_back(edge_n);
      default: ;
    endcase
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] p[$], input int gap_at, input int gap,
                          output int unsigned last_edge);
    int v, dec;
    int unsigned e;
    v = verdict(p, dec);
    send_byte(SYNC, 0, e);
    last_edge = e;
    for (int i = 0; i < p.size(); i++) begin
      if (i == gap_at) idle(gap);
      if (i == dec && v == 1)
        for (int k = 1; k <= int'(p[0]); k++) exp_q.push_back({k == int'(p[0]), p[k]});
      send_byte(p[i], (i == dec) ? v : 0, e);
      last_edge = e;
      if (i == dec) break;
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < 3000) begin
      tick();
      n++;
    end
    chk({name, "_drain_bound"}, 32'(n < 3000), 32'd1);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({name, "_out_last"}, 32'(bus.out_last), 32'd0);
    chk({name, "_out_data"}, 32'(bus.out_data), 32'd0);
    chk({name, "_pkt_ok"}, 32'(bus.pkt_ok), 32'd0);
    chk({name, "_pkt_err"}, 32'(bus.pkt_err), 32'd0);
    chk({name, "_drop"}, 32'(bus.drop), 32'd0);
    chk({name, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  p[$];
    logic [7:0]  body[$];
    int          dec;
    int unsigned e;

    bus.rx_data   = 8'h00;
    bus.rx_valid  = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    idle(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    idle(2);

    // Model pinned against hand-computed values
    body = '{8'h03, 8'h11, 8'h22, 8'h33};
    chk("model_csum3", 32'(csum_of(body)), 32'h97);
    p = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    chk("model_good3", 32'(verdict(p, dec)), 32'd1);
    p = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h87};
    chk("model_bad3", 32'(verdict(p, dec)), 32'd2);
    p = '{8'h11};
    chk("model_len17", 32'(verdict(p, dec)), 32'd2);
    body = '{8'h10};
    for (int i = 1; i <= 16; i++) body.push_back(8'(i));
    chk("model_csum16", 32'(csum_of(body)), 32'h68);

    // Non-SYNC bytes in IDLE are ignored silently
    send_byte(8'h00, 0, e);
    send_byte(8'hFF, 0, e);
    send_byte(8'h5A, 0, e);
    chk("idle_garbage_busy", 32'(bus.busy), 32'd0);

    // Good packet, consumer always ready: three back-to-back bytes
    p = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    send_pkt(p, -1, 0, e);
    idle(3);
    chk("burst_consecutive", 32'(exp_q.size()), 32'd0);
    wait_idle("good3");

    // Bad checksums
    p = '{8'h02, 8'h10, 8'h20, 8'h00};
    send_pkt(p, -1, 0, e);
    chk("busy_after_bad_csum", 32'(bus.busy), 32'd0);
    idle(2);
    p = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h87};
    send_pkt(p, -1, 0, e);
    idle(2);

    // Length bounds
    p = '{8'h00};
    send_pkt(p, -1, 0, e);
    chk("busy_after_len0", 32'(bus.busy), 32'd0);
    idle(2);
    p = '{8'h11};
    send_pkt(p, -1, 0, e);
    idle(2);
    p = body;
    p.push_back(csum_of(body));
    send_pkt(p, -1, 0, e);
    wait_idle("len16");

    // Timeout after silence
    p = '{8'h02, 8'h10};
    send_pkt(p, -1, 0, e);
    err_q.push_back(e + TIMEOUT);
    chk("busy_in_payload", 32'(bus.busy), 32'd1);
    idle(TIMEOUT - 1);
    chk("busy_before_expiry", 32'(bus.busy), 32'd1);
    idle(1);
    chk("busy_after_expiry", 32'(bus.busy), 32'd0);
    idle(2);

    // Byte arriving exactly in the expiry cycle wins
    p = '{8'h02, 8'h10, 8'h20, 8'hCE};
    send_pkt(p, 2, TIMEOUT - 1, e);
    wait_idle("expiry_byte");

    // Backpressure with bytes arriving during DRAIN
    bus.out_ready = 1'b0;
    p = '{8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF2};
    send_pkt(p, -1, 0, e);
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          bus.out_ready = (i % 2 == 1);
          tick();
        end
        bus.out_ready = 1'b1;
      end
      begin
        int unsigned e2;
        send_byte(8'h55, 3, e2);
        send_byte(SYNC, 3, e2);
        send_byte(8'h04, 3, e2);
      end
    join
    wait_idle("backpressure");
    p = '{8'h01, 8'h5A, 8'hA5};
    send_pkt(p, -1, 0, e);
    wait_idle("after_drain");

    // Reset in the middle of a payload
    p = '{8'h04, 8'h01};
    send_pkt(p, -1, 0, e);
    idle(1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midpkt_reset");
    idle(2);
    rst_n = 1'b1;
    idle(1);
    p = '{8'h02, 8'hC0, 8'hDE, 8'h60};
    send_pkt(p, -1, 0, e);
    wait_idle("post_reset");
    idle(3);

    chk("ok_q_empty", 32'(ok_q.size()), 32'd0);
    chk("err_q_empty", 32'(err_q.size()), 32'd0);
    chk("drop_q_empty", 32'(drop_q.size()), 32'd0);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
